set_job_arbiter: RTL

- Shares one SET set-counting engine (en/busy/valid/candidate handshake, 24-bit central, 12-bit radius, 2-bit mode, 8-bit candidate) between N_REQ independent requesters.
- Arbitrates jobs round-robin, issues each job to the engine as a single-cycle en pulse, waits for valid, and routes the candidate back to the originating requester.
- Sits between the requester clients and the SET core instance, which shares the same clk/rst.

---
 rtl/set_arb_pkg.sv | 21 ++
 rtl/set_rr_picker.sv | 32 +++
 rtl/set_job_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/set_arb_pkg.sv
// Shared widths, set-operation mode codes and arbiter state encoding for the SET job arbiter.
package set_arb_pkg;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;

    localparam logic [MODE_W-1:0] MODE_A         = 2'b00;
    localparam logic [MODE_W-1:0] MODE_UNION     = 2'b01;
    localparam logic [MODE_W-1:0] MODE_DIFF      = 2'b10;
    localparam logic [MODE_W-1:0] MODE_INTERSECT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/set_rr_picker.sv
// Combinational round-robin selector: first set req bit strictly after last, wrapping.
// Zero latency; no state, so the caller decides when a pick is consumed.
module set_rr_picker #(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = 0;
        // Offsets 1..N_REQ visit every requester once, the previous winner last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!any && req[cand]) begin
                any              = 1'b1;
                gnt_idx          = IDX_W'(cand);
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_job_arbiter.sv
// Round-robin sharing of one SET engine: IDLE grant -> 1-cycle ISSUE (eng_en/ack) -> WAIT -> 1-cycle RESP.
// Grants stall while eng_busy is high; optional WAIT timeout under SET_ARB_WATCHDOG_EN.
module set_job_arbiter
    import set_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [CENTRAL_W*N_REQ-1:0]   req_central,
    input  logic [RADIUS_W*N_REQ-1:0]    req_radius,
    input  logic [MODE_W*N_REQ-1:0]      req_mode,
    output logic [N_REQ-1:0]             ack,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [CAND_W-1:0]            rsp_candidate,
    output logic [$clog2(N_REQ)-1:0]     rsp_id,
    output logic                         rsp_err,
    output logic                         arb_busy,
    output logic                         eng_en,
    output logic [CENTRAL_W-1:0]         eng_central,
    output logic [RADIUS_W-1:0]          eng_radius,
    output logic [MODE_W-1:0]            eng_mode,
    input  logic                         eng_busy,
    input  logic                         eng_valid,
    input  logic [CAND_W-1:0]            eng_candidate
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_param_check
        $error("set_job_arbiter: N_REQ or TIMEOUT_CYC out of range");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] last, id;
    logic [N_REQ-1:0] id_oh;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant;
    logic             result_take;

    set_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (req),
        .last       (last),
        .gnt_onehot (pick_oh),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

`ifdef SET_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_cnt;
    logic        wd_fire;
    logic        err_q;
`endif

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        result_take = 1'b0;
`ifdef SET_ARB_WATCHDOG_EN
        wd_fire     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_any && !eng_busy) begin
                    grant     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts as a good result.
                if (eng_valid) begin
                    result_take = 1'b1;
                    state_nxt   = ST_RESP;
                end
`ifdef SET_ARB_WATCHDOG_EN
                else if (wd_cnt == WD_LIMIT) begin
                    wd_fire   = 1'b1;
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last          <= IDX_W'(N_REQ - 1);
            id            <= '0;
            id_oh         <= '0;
            eng_central   <= '0;
            eng_radius    <= '0;
            eng_mode      <= '0;
            rsp_candidate <= '0;
            rsp_id        <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                id          <= pick_idx;
                id_oh       <= pick_oh;
                last        <= pick_idx;
                eng_central <= req_central[pick_idx*CENTRAL_W +: CENTRAL_W];
                eng_radius  <= req_radius[pick_idx*RADIUS_W +: RADIUS_W];
                eng_mode    <= req_mode[pick_idx*MODE_W +: MODE_W];
            end
            if (result_take) begin
                rsp_candidate <= eng_candidate;
                rsp_id        <= id;
            end
`ifdef SET_ARB_WATCHDOG_EN
            else if (wd_fire) begin
                rsp_candidate <= '0;
                rsp_id        <= id;
            end
`endif
        end
    end

`ifdef SET_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_ISSUE)
                wd_cnt <= '0;
            else if (state == ST_WAIT)
                wd_cnt <= wd_cnt + 16'd1;
            if (state == ST_WAIT && state_nxt == ST_RESP)
                err_q <= wd_fire;
        end
    end

    assign rsp_err = (state == ST_RESP) && err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign eng_en    = (state == ST_ISSUE);
    assign ack       = (state == ST_ISSUE) ? id_oh : '0;
    assign rsp_valid = (state == ST_RESP)  ? id_oh : '0;
    assign arb_busy  = (state != ST_IDLE);

endmodule
